bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Two-master arbiter for the single 32-bit system bus, which carries ROM/RAM/EXCP BRAMs, DigitalPort A/B and Timer.
- Master 0 is the CPU. Master 1 is a secondary requester, e.g. a debug/boot loader writing ROM, or a DMA engine.
- Sits between the masters and the bus decode/memory logic.
- Serialises whole valid/ready transactions: a transaction is never split or interleaved.
- Guarantees that a stale busReady from the previous transaction is never forwarded to the next master.

Parameters:
- FIXED_PRIORITY, 0: 0 = round-robin; 1 = master 0 always wins a simultaneous request.
- TIMEOUT_CYCLES, 255: watchdog limit in cycles; used only with BUS_ARB_TIMEOUT_EN.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-high reset
- m0Valid  input  1  master 0 request; held until m0Ready
- m0Instr  input  1  master 0 instruction-fetch flag
- m0WriteEnable  input  1  master 0 write
- m0Address  input  32  master 0 address
- m0DataOut  input  32  master 0 write data
- m0DataIn  output  32  read data to master 0
- m0Ready  output  1  transaction complete for master 0
- m1Valid, m1Instr, m1WriteEnable, m1Address, m1DataOut, m1DataIn, m1Ready: same as master 0, for master 1
- busValid  output  1  to bus
- busInstr  output  1  to bus
- busWriteEnable  output  1  to bus
- busAddress  output  32  to bus
- busDataIn  output  32  write data to bus
- busDataOut  input  32  read data from bus
- busReady  input  1  from bus; rises the cycle after busValid, stays high while busValid is held
- grant  output  2  one-hot current owner (00 = none)
- busError  output  1  one-cycle pulse: transaction aborted by timeout (BUS_ARB_TIMEOUT_EN only; otherwise tied 0)

Behaviour:

Reset:
- Async assert: state=IDLE, grant=00, lastOwner=1 (so master 0 wins first under round-robin), all outputs 0.

States:
- IDLE
  - No request: stay in IDLE.
  - Exactly one mValid: go to OWN, owner = that master.
  - Both requesting: FIXED_PRIORITY=1 → master 0; otherwise the master that is not lastOwner.
  - Decision is registered: busValid rises the cycle after entry to OWN. Minimum added latency is 1 cycle.
- OWN
  - Bus outputs combinationally mirror the owner's valid/instr/writeEnable/address/data.
  - Owner's mReady = busReady && mValid(owner).
  - Owner's mDataIn = busDataOut.
  - Non-owner: mReady=0, mDataIn=0.
  - Owner drops mValid: go to DRAIN; busValid=0 immediately, since it mirrors the owner.
  - Owner drops mValid without ever seeing ready: treated as an abandon, same path to DRAIN.
- DRAIN
  - All bus outputs forced 0; no mReady to anyone.
  - Wait until busReady==0, then go to IDLE; lastOwner = owner.
  - Minimum DRAIN length is 1 cycle.

Boundary conditions:
- Back-to-back requests from the same master still pass IDLE; a new request can only be granted in IDLE.
- No starvation under round-robin: continuous requests from both masters strictly alternate.
- Reset asserted mid-transaction: immediate return to IDLE. Masters must restart their requests.
- The arbiter is purely sequencing; it never inspects address or data.

Optional Feature:
- Macro: BUS_ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter increments in OWN while busValid && !busReady.
  - On reaching TIMEOUT_CYCLES:
    - busError pulses for 1 cycle.
    - The owner receives a one-cycle mReady with mDataIn=32'hDEADBEEF.
    - State goes to DRAIN.
  - The counter clears on every entry to OWN.
- Without the macro:
  - No counter.
  - busError is constant 0.
  - A stuck slave hangs the bus indefinitely.

Decomposition:
- Shared package holds:
  - arbiter state encoding: IDLE=2'd0, OWN=2'd1, DRAIN=2'd2
  - GRANT_NONE / GRANT_M0 / GRANT_M1 one-hot constants
  - TIMEOUT_DATA = 32'hDEADBEEF
- One natural sub-module: bus_arb_select.
  - Pure combinational.
  - Inputs: two requests, lastOwner, FIXED_PRIORITY.
  - Output: winner.
  - Reused by any future N-master variant.

Test Plan:
1. Master 0 only: m0 reads 0x00000010 with ROM word 0x12345678 → grant=01 one cycle later; m0Ready pulses with m0DataIn=0x12345678; DRAIN then IDLE; m1Ready stays 0 throughout.
2. Simultaneous m0/m1 writes, FIXED_PRIORITY=0, after reset → m0 served first, then m1. Repeat 4 times: grant sequence is 01,10,01,10,…
3. FIXED_PRIORITY=1, both continuously requesting → m0 granted every time; m1 never granted while m0 requests. Then drop m0 → m1 granted within 3 cycles.
4. Stale-ready check: bus model keeps busReady high 2 extra cycles after busValid drops → arbiter stays in DRAIN; no mReady to the next master until busReady==0.
5. Async reset asserted while in OWN with m1 write in flight → all outputs 0 in the same cycle; grant=00; after release, a new m0 request is served normally.
6. With BUS_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never readies → after 8 cycles busError=1 for one cycle, m0Ready=1 with m0DataIn=0xDEADBEEF, then IDLE.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the two-master system bus arbiter.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  localparam logic [1:0]  GRANT_NONE   = 2'b00;
  localparam logic [1:0]  GRANT_M0     = 2'b01;
  localparam logic [1:0]  GRANT_M1     = 2'b10;
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

  function automatic logic [1:0] grant_onehot(input logic owner);
    return owner ? GRANT_M1 : GRANT_M0;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// One valid/ready bus link. Names follow the requester's view: dataOut is
// write data towards the slave, dataIn is read data back to the requester.
interface bus_arbiter_if;
  logic        valid;
  logic        instr;
  logic        writeEnable;
  logic [31:0] address;
  logic [31:0] dataOut;
  logic [31:0] dataIn;
  logic        ready;

  modport master (
    output valid, instr, writeEnable, address, dataOut,
    input  dataIn, ready
  );

  modport slave (
    input  valid, instr, writeEnable, address, dataOut,
    output dataIn, ready
  );
endinterface

// File: rtl/bus_arbiter_select.sv
// Winner selection for the two-master arbiter (pure combinational).
module bus_arb_select
  import bus_arbiter_pkg::*;
#(
  parameter int FIXED_PRIORITY = 0
) (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_owner,
  output logic o_winner
);

  always_comb begin
    o_winner = 1'b0;
    if (i_req0 && i_req1) begin
      // Round-robin hands a tie to whoever did not own the bus last.
      o_winner = (FIXED_PRIORITY != 0) ? 1'b0 : ~i_last_owner;
    end else if (i_req1) begin
      o_winner = 1'b1;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master arbiter serialising whole valid/ready transactions onto the system bus.
// Optional watchdog abort is built only when BUS_ARB_TIMEOUT_EN is defined.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int FIXED_PRIORITY = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter_if.slave  m0,
  bus_arbiter_if.slave  m1,
  bus_arbiter_if.master bus,
  output logic [1:0]    grant,
  output logic          busError
);

  arb_state_t  r_state;
  arb_state_t  w_next_state;
  logic        r_owner;
  logic        w_next_owner;
  logic        r_last_owner;
  logic        w_next_last;
  logic        w_winner;
  logic        w_own_valid;
  logic        w_own_ready;
  logic [31:0] w_own_rdata;
  logic        w_timeout;

  bus_arb_select #(
    .FIXED_PRIORITY (FIXED_PRIORITY)
  ) u_select (
    .i_req0       (m0.valid),
    .i_req1       (m1.valid),
    .i_last_owner (r_last_owner),
    .o_winner     (w_winner)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
    end else begin
      r_state      <= w_next_state;
      r_owner      <= w_next_owner;
      r_last_owner <= w_next_last;
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  // Leaving OWN clears the count, so every new ownership starts from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_state != OWN) begin
      r_cnt <= '0;
    end else if (w_own_valid && !bus.ready) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end
`endif

  always_comb begin
    w_next_state    = r_state;
    w_next_owner    = r_owner;
    w_next_last     = r_last_owner;
    w_own_valid     = r_owner ? m1.valid : m0.valid;
    w_own_ready     = 1'b0;
    w_own_rdata     = 32'h0;
    w_timeout       = 1'b0;
    grant           = GRANT_NONE;
    bus.valid       = 1'b0;
    bus.instr       = 1'b0;
    bus.writeEnable = 1'b0;
    bus.address     = 32'h0;
    bus.dataOut     = 32'h0;

    case (r_state)
      IDLE: begin
        if (m0.valid || m1.valid) begin
          w_next_state = OWN;
          w_next_owner = w_winner;
        end
      end

      OWN: begin
        grant           = grant_onehot(r_owner);
        bus.valid       = w_own_valid;
        bus.instr       = r_owner ? m1.instr       : m0.instr;
        bus.writeEnable = r_owner ? m1.writeEnable : m0.writeEnable;
        bus.address     = r_owner ? m1.address     : m0.address;
        bus.dataOut     = r_owner ? m1.dataOut     : m0.dataOut;
        w_own_ready     = bus.ready && w_own_valid;
        w_own_rdata     = bus.dataIn;
`ifdef BUS_ARB_TIMEOUT_EN
        if (w_own_valid && !bus.ready && (r_cnt == CNT_LAST)) begin
          w_timeout    = 1'b1;
          w_own_ready  = 1'b1;
          w_own_rdata  = TIMEOUT_DATA;
          w_next_state = DRAIN;
        end
`endif
        // Normal completion and abandon both leave through DRAIN.
        if (!w_own_valid) begin
          w_next_state = DRAIN;
        end
      end

      DRAIN: begin
        if (!bus.ready) begin
          w_next_state = IDLE;
          w_next_last  = r_owner;
        end
      end

      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_comb begin
    m0.ready  = w_own_ready && !r_owner;
    m1.ready  = w_own_ready &&  r_owner;
    m0.dataIn = r_owner ? 32'h0 : w_own_rdata;
    m1.dataIn = r_owner ? w_own_rdata : 32'h0;
  end

  assign busError = w_timeout;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: round-robin and fixed-priority instances
// driven by simple bus slave models; timeout case runs when BUS_ARB_TIMEOUT_EN is set.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam logic [31:0] ROM_KEY = 32'h12345668;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bus_arbiter_if a_m0 ();
  bus_arbiter_if a_m1 ();
  bus_arbiter_if a_bus ();
  bus_arbiter_if b_m0 ();
  bus_arbiter_if b_m1 ();
  bus_arbiter_if b_bus ();

  logic [1:0] a_grant, b_grant;
  logic       a_err, b_err;

  bus_arbiter #(.FIXED_PRIORITY(0), .TIMEOUT_CYCLES(8)) u_a (
    .clk(clk), .reset(reset), .m0(a_m0), .m1(a_m1), .bus(a_bus),
    .grant(a_grant), .busError(a_err)
  );

  bus_arbiter #(.FIXED_PRIORITY(1), .TIMEOUT_CYCLES(8)) u_b (
    .clk(clk), .reset(reset), .m0(b_m0), .m1(b_m1), .bus(b_bus),
    .grant(b_grant), .busError(b_err)
  );

  // Slave model A: ready one cycle after valid, optional stale hold, optional stuck.
  logic        a_rdy;
  int          a_hold;
  int          a_extra = 0;
  bit          a_stuck = 1'b0;
  int          a_wcnt;
  logic [31:0] a_wlast;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      a_rdy   <= 1'b0;
      a_hold  <= 0;
      a_wcnt  <= 0;
      a_wlast <= 32'h0;
    end else begin
      if (a_bus.valid && a_rdy && a_bus.writeEnable) begin
        a_wcnt  <= a_wcnt + 1;
        a_wlast <= a_bus.dataOut;
      end
      if (a_bus.valid && !a_stuck) begin
        a_rdy  <= 1'b1;
        a_hold <= a_extra;
      end else if (a_rdy && a_hold != 0) begin
        a_hold <= a_hold - 1;
      end else begin
        a_rdy <= 1'b0;
      end
    end
  end
  assign a_bus.ready  = a_rdy;
  assign a_bus.dataIn = a_rdy ? (a_bus.address ^ ROM_KEY) : 32'h0;

  logic b_rdy;
  always @(posedge clk or posedge reset) begin
    if (reset) b_rdy <= 1'b0;
    else       b_rdy <= b_bus.valid;
  end
  assign b_bus.ready  = b_rdy;
  assign b_bus.dataIn = b_rdy ? (b_bus.address ^ ROM_KEY) : 32'h0;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  int          pa0, pa1, pb0, pb1, da0, da1, db0, db1;
  logic [31:0] rd_a0, rd_a1;
  logic [1:0]  g_a, g_b, pg_a, pg_b;
  logic [1:0]  la [32];
  logic [1:0]  lb [32];
  int          la_n, lb_n, spur_a, rdy_a1, drain_a, err_a, own0_a;

  task automatic clr();
    pa0 = 0; pa1 = 0; pb0 = 0; pb1 = 0;
    da0 = 0; da1 = 0; db0 = 0; db1 = 0;
    la_n = 0; lb_n = 0; spur_a = 0; rdy_a1 = 0;
    drain_a = 0; err_a = 0; own0_a = 0;
    rd_a0 = 32'h0; rd_a1 = 32'h0;
  endtask

  // One clock: sample at negedge, then update master requests just after posedge.
  task automatic step();
    logic sa0, sa1, sb0, sb1;
    @(negedge clk);
    sa0 = a_m0.valid && a_m0.ready;
    sa1 = a_m1.valid && a_m1.ready;
    sb0 = b_m0.valid && b_m0.ready;
    sb1 = b_m1.valid && b_m1.ready;
    if (sa0) rd_a0 = a_m0.dataIn;
    if (sa1) rd_a1 = a_m1.dataIn;
    g_a = a_grant;
    g_b = b_grant;
    if (g_a != GRANT_NONE && pg_a == GRANT_NONE && la_n < 32) begin la[la_n] = g_a; la_n++; end
    if (g_b != GRANT_NONE && pg_b == GRANT_NONE && lb_n < 32) begin lb[lb_n] = g_b; lb_n++; end
    pg_a = g_a;
    pg_b = g_b;
    if ((a_m0.ready && a_grant != GRANT_M0) || (a_m1.ready && a_grant != GRANT_M1)) spur_a++;
    if (a_m1.ready) rdy_a1++;
    if (u_a.r_state == DRAIN) drain_a++;
    if (a_err) err_a++;
    if (a_grant == GRANT_M0) own0_a++;
    @(posedge clk);
    #1;
    if (sa0) begin a_m0.valid = 1'b0; da0++; end
    else if (!a_m0.valid && pa0 > 0) begin a_m0.valid = 1'b1; pa0--; end
    if (sa1) begin a_m1.valid = 1'b0; da1++; end
    else if (!a_m1.valid && pa1 > 0) begin a_m1.valid = 1'b1; pa1--; end
    if (sb0) begin b_m0.valid = 1'b0; db0++; end
    else if (!b_m0.valid && pb0 > 0) begin b_m0.valid = 1'b1; pb0--; end
    if (sb1) begin b_m1.valid = 1'b0; db1++; end
    else if (!b_m1.valid && pb1 > 0) begin b_m1.valid = 1'b1; pb1--; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int n_m1;
    a_m0.valid = 0; a_m0.instr = 0; a_m0.writeEnable = 0; a_m0.address = 0; a_m0.dataOut = 0;
    a_m1.valid = 0; a_m1.instr = 0; a_m1.writeEnable = 0; a_m1.address = 0; a_m1.dataOut = 0;
    b_m0.valid = 0; b_m0.instr = 0; b_m0.writeEnable = 0; b_m0.address = 0; b_m0.dataOut = 0;
    b_m1.valid = 0; b_m1.instr = 0; b_m1.writeEnable = 0; b_m1.address = 0; b_m1.dataOut = 0;
    pg_a = GRANT_NONE; pg_b = GRANT_NONE;
    clr();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", 32'(a_grant), 32'(GRANT_NONE));
    chk("rst_bus_valid", 32'(a_bus.valid), 32'h0);
    chk("rst_m0_ready", 32'(a_m0.ready), 32'h0);
    chk("rst_busError", 32'(a_err), 32'h0);
    chk("rst_state", 32'(u_a.r_state), 32'(IDLE));
    reset = 1'b0;

    // Test 1: master 0 alone reads ROM word
    a_m0.instr = 1'b1; a_m0.writeEnable = 1'b0; a_m0.address = 32'h10;
    a_m0.valid = 1'b1;
    step();
    chk("t1_grant_pre", 32'(g_a), 32'(GRANT_NONE));
    step();
    chk("t1_grant", 32'(g_a), 32'(GRANT_M0));
    chk("t1_bus_addr", a_bus.address, 32'h10);
    chk("t1_bus_instr", 32'(a_bus.instr), 32'h1);
    for (k = 0; k < 10 && da0 == 0; k++) step();
    chk("t1_done", 32'(da0), 32'h1);
    chk("t1_rdata", rd_a0, 32'h12345678);
    step();
    chk("t1_drain", 32'(u_a.r_state), 32'(DRAIN));
    step();
    chk("t1_idle", 32'(u_a.r_state), 32'(IDLE));
    chk("t1_m1_ready", 32'(rdy_a1), 32'h0);

    // Test 2: simultaneous writes alternate under round-robin
    a_m0.instr = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    clr();
    a_m0.writeEnable = 1'b1; a_m0.address = 32'h100; a_m0.dataOut = 32'h0BAD0000;
    a_m1.writeEnable = 1'b1; a_m1.address = 32'h200; a_m1.dataOut = 32'hCAFE0001;
    pa0 = 4; pa1 = 4;
    for (k = 0; k < 200 && !(da0 == 4 && da1 == 4); k++) step();
    chk("t2_done", 32'(da0 + da1), 32'd8);
    chk("t2_grants", 32'(la_n), 32'd8);
    for (int i = 0; i < 8; i++) chk($sformatf("t2_grant%0d", i), 32'(la[i]), (i % 2 == 0) ? 32'(GRANT_M0) : 32'(GRANT_M1));
    chk("t2_writes", 32'(a_wcnt), 32'd8);
    chk("t2_last_wdata", a_wlast, 32'hCAFE0001);
    chk("t2_spurious_ready", 32'(spur_a), 32'h0);

    // Test 3: fixed priority starves master 1 until master 0 stops
    clr();
    b_m0.writeEnable = 1'b1; b_m0.address = 32'h300; b_m0.dataOut = 32'h11111111;
    b_m1.writeEnable = 1'b1; b_m1.address = 32'h400; b_m1.dataOut = 32'h22222222;
    pb0 = 4; pb1 = 4;
    for (k = 0; k < 200 && db0 < 4; k++) step();
    chk("t3_m0_done", 32'(db0), 32'd4);
    n_m1 = 0;
    for (int i = 0; i < lb_n; i++) if (lb[i] == GRANT_M1) n_m1++;
    chk("t3_m1_granted_early", 32'(n_m1), 32'h0);
    chk("t3_m0_grants", 32'(lb_n), 32'd4);
    for (k = 0; k < 10 && g_b != GRANT_M1; k++) step();
    chk("t3_m1_latency_ok", 32'(k <= 4), 32'h1);
    for (k = 0; k < 200 && db1 < 4; k++) step();
    chk("t3_m1_done", 32'(db1), 32'd4);

    // Test 4: stale busReady held two extra cycles after busValid drops
    clr();
    a_extra = 2;
    a_m0.writeEnable = 1'b0; a_m0.address = 32'h20;
    a_m1.writeEnable = 1'b0; a_m1.address = 32'h40;
    pa0 = 1; pa1 = 1;
    for (k = 0; k < 100 && !(da0 == 1 && da1 == 1); k++) step();
    chk("t4_done", 32'(da0 + da1), 32'd2);
    chk("t4_order0", 32'(la[0]), 32'(GRANT_M0));
    chk("t4_order1", 32'(la[1]), 32'(GRANT_M1));
    chk("t4_drain_cycles", 32'(drain_a), 32'd3);
    chk("t4_stale_forward", 32'(spur_a), 32'h0);
    chk("t4_rdata_m0", rd_a0, 32'h20 ^ ROM_KEY);
    chk("t4_rdata_m1", rd_a1, 32'h40 ^ ROM_KEY);
    a_extra = 0;
    repeat (6) step();

    // Test 5: async reset during master 1 write
    clr();
    a_m1.writeEnable = 1'b1; a_m1.address = 32'h80; a_m1.dataOut = 32'h5555AAAA;
    pa1 = 1;
    for (k = 0; k < 20 && g_a != GRANT_M1; k++) step();
    chk("t5_granted", 32'(g_a), 32'(GRANT_M1));
    reset = 1'b1;
    #1;
    chk("t5_grant", 32'(a_grant), 32'(GRANT_NONE));
    chk("t5_bus_valid", 32'(a_bus.valid), 32'h0);
    chk("t5_bus_we", 32'(a_bus.writeEnable), 32'h0);
    chk("t5_bus_addr", a_bus.address, 32'h0);
    chk("t5_bus_wdata", a_bus.dataOut, 32'h0);
    chk("t5_m1_ready", 32'(a_m1.ready), 32'h0);
    a_m1.valid = 1'b0;
    pa1 = 0;
    step();
    step();
    reset = 1'b0;
    clr();
    a_m0.writeEnable = 1'b0; a_m0.address = 32'h30;
    pa0 = 1;
    for (k = 0; k < 20 && da0 == 0; k++) step();
    chk("t5_m0_after_reset", 32'(da0), 32'h1);
    chk("t5_m0_rdata", rd_a0, 32'h30 ^ ROM_KEY);
    chk("t5_m0_grant", 32'(la[0]), 32'(GRANT_M0));
    repeat (3) step();

`ifdef BUS_ARB_TIMEOUT_EN
    // Test 6: stuck slave aborted by watchdog
    clr();
    a_stuck = 1'b1;
    a_m0.writeEnable = 1'b0; a_m0.address = 32'h44;
    pa0 = 1;
    for (k = 0; k < 40 && da0 == 0; k++) step();
    chk("t6_done", 32'(da0), 32'h1);
    chk("t6_rdata", rd_a0, 32'hDEADBEEF);
    chk("t6_own_cycles", 32'(own0_a), 32'd8);
    step();
    step();
    chk("t6_busError_pulses", 32'(err_a), 32'h1);
    chk("t6_idle", 32'(u_a.r_state), 32'(IDLE));
    a_stuck = 1'b0;
`else
    chk("no_timeout_busError", 32'(err_a), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
